// File: rtl/cp0_exc_unit_pkg.sv
// cp0_exc_unit_pkg
//   Shared constants for the CP0 exception responder: exception codes,
//   CP0 register numbers, SR/Cause field positions and default contents.
//   It has no ports. The other CP0 files pull it in with
//   "import cp0_exc_unit_pkg::*".
package cp0_exc_unit_pkg;

  // Exception codes carried down the pipe
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE_DEFAULT = 5'd31;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR / Cause field positions
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IE_BIT    = 0;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  // Handler entry; fetch owns the redirect, so it is kept here for reference
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE_DEFAULT   = 32'h2020_0707;

  // Word-align an address by clearing its two low bits
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
//   Coprocessor-0 exception responder. Decides whether to take an exception
//   or an interrupt for the instruction in M, and then captures SR/Cause/EPC.
//   It also serves mfc0 reads and mtc0 writes.
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   RdAddr     : mfc0 register number
//   WrAddr/WrData/WrEn : mtc0 register number, data and strobe (M stage)
//   PC_M, BD_M, ExcCode_M : victim PC, delay-slot flag and exception code in M
//   HWInt      : six level-sensitive interrupt lines
//   EXLClr     : eret retiring in M
//   RdData     : mfc0 read data (combinational, shows pre-edge state)
//   ErrSignal  : take-exception request (combinational)
//   EPCData    : eret target, with same-cycle mtc0 EPC forwarded
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [4:0]  EXC_NONE   = EXC_NONE_DEFAULT,
  parameter logic [31:0] PRID_VALUE = PRID_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RdAddr,
  input  logic [4:0]  WrAddr,
  input  logic [31:0] WrData,
  input  logic        WrEn,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] RdData,
  output logic        ErrSignal,
  output logic [31:0] EPCData
);

  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] victim_pc;

  assign int_req   = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req   = (ExcCode_M != EXC_NONE) & ~sr_exl_q;
  assign ErrSignal = int_req | exc_req;

  assign wr_sr  = WrEn & (WrAddr == CP0_SR);
  assign wr_epc = WrEn & (WrAddr == CP0_EPC);

  // A delay-slot victim restarts at its branch so the branch re-executes
  assign victim_pc = BD_M ? (PC_M - 32'd4) : PC_M;

  // Forward an mtc0 EPC so an eret one instruction behind sees the new value
  assign EPCData = wr_epc ? word_align(WrData) : epc_q;

  always_comb begin
    RdData = 32'h0;
    case (RdAddr)
      CP0_SR: begin
        RdData[SR_IM_LO +: 6] = sr_im_q;
        RdData[SR_EXL_BIT]    = sr_exl_q;
        RdData[SR_IE_BIT]     = sr_ie_q;
      end
      CP0_CAUSE: begin
        RdData[CAUSE_BD_BIT]       = cause_bd_q;
        RdData[CAUSE_IP_LO +: 6]   = cause_ip_q;
        RdData[CAUSE_EXC_LO +: 5]  = cause_exc_q;
      end
      CP0_EPC:  RdData = epc_q;
      CP0_PRID: RdData = PRID_VALUE;
      default:  RdData = 32'h0;
    endcase
  end

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    // Pending lines are sampled raw, regardless of masks or EXL
    cause_ip_d  = HWInt;

    if (ErrSignal) begin
      // The M instruction is cancelled, so any mtc0 it carries is dropped
      sr_exl_d    = 1'b1;
      cause_bd_d  = BD_M;
      epc_d       = word_align(victim_pc);
      cause_exc_d = int_req ? EXC_INT : ExcCode_M;
    end else begin
      if (wr_sr) begin
        sr_im_d  = WrData[SR_IM_LO +: 6];
        sr_exl_d = WrData[SR_EXL_BIT];
        sr_ie_d  = WrData[SR_IE_BIT];
      end
      if (wr_epc) begin
        epc_d = word_align(WrData);
      end
      // eret takes precedence over an mtc0 for the EXL bit only
      if (EXLClr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit
//   Directed bench for cp0_exc_unit. Inputs change on the falling edge, and
//   outputs are checked a little later in that same low phase.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  RdAddr;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic        WrEn;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] RdData;
  logic        ErrSignal;
  logic [31:0] EPCData;

  int n_vec;
  int n_bad;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .RdAddr    (RdAddr),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .WrEn      (WrEn),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .RdData    (RdData),
    .ErrSignal (ErrSignal),
    .EPCData   (EPCData)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  // Advance one full clock, ending in the low phase
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    RdAddr = addr;
    #1;
    check_val(tag, RdData, exp);
  endtask

  task automatic err(input logic exp, input string tag);
    #1;
    check_val(tag, {31'b0, ErrSignal}, {31'b0, exp});
  endtask

  task automatic idle();
    WrEn = 1'b0; WrAddr = 5'd0; WrData = 32'h0;
    ExcCode_M = 5'd31; BD_M = 1'b0; EXLClr = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0; RdAddr = 5'd0; PC_M = 32'h0; HWInt = 6'b0;
    idle();

    // 1: reset state
    step(); step();
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h2020_0707, "prid");
    err(1'b0, "rst_err");
    reset = 1'b1;

    // 2: enable IM0+IE, then raise HWInt[0]
    WrEn = 1'b1; WrAddr = 5'd12; WrData = 32'h0000_0401;
    step();
    idle();
    rd(5'd12, 32'h0000_0401, "mtc0_sr");
    HWInt = 6'b000001; PC_M = 32'h0000_1000;
    err(1'b1, "int_err");
    step();
    err(1'b0, "int_masked_by_exl");
    HWInt = 6'b0;
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr");
    rd(5'd14, 32'h0000_1000, "int_epc");

    // 3: AdEL in a delay slot
    EXLClr = 1'b1;
    step();
    idle();
    rd(5'd12, 32'h0000_0401, "eret_sr");
    ExcCode_M = 5'd4; PC_M = 32'h0000_3001; BD_M = 1'b1;
    err(1'b1, "adel_err");
    step();
    idle();
    rd(5'd14, 32'h0000_2ffc, "adel_epc");
    rd(5'd13, 32'h8000_0010, "adel_cause");

    // 4: nesting blocked while EXL=1
    ExcCode_M = 5'd12; HWInt = 6'b000001; PC_M = 32'h0000_5000;
    err(1'b0, "nest_err");
    step();
    ExcCode_M = 5'd31;
    rd(5'd14, 32'h0000_2ffc, "nest_epc");
    rd(5'd13, 32'h8000_0410, "nest_cause");
    EXLClr = 1'b1;
    err(1'b0, "eret_cycle_err");
    step();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret2_sr");
    err(1'b1, "int_after_eret");
    step();
    rd(5'd14, 32'h0000_5000, "int2_epc");
    rd(5'd13, 32'h0000_0400, "int2_cause");

    // 5: interrupt + RI + mtc0 EPC in one cycle
    HWInt = 6'b0; EXLClr = 1'b1;
    step();
    idle();
    HWInt = 6'b000001; ExcCode_M = 5'd10; PC_M = 32'h0000_6000;
    WrEn = 1'b1; WrAddr = 5'd14; WrData = 32'h0000_1234;
    err(1'b1, "combo_err");
    check_val("combo_fwd", EPCData, 32'h0000_1234);
    step();
    idle();
    HWInt = 6'b0;
    rd(5'd14, 32'h0000_6000, "combo_epc");
    rd(5'd13, 32'h0000_0400, "combo_cause");

    // 6: mtc0 EPC alongside eret
    WrEn = 1'b1; WrAddr = 5'd14; WrData = 32'h0000_3a07; EXLClr = 1'b1;
    #1;
    check_val("fwd_epcdata", EPCData, 32'h0000_3a04);
    step();
    idle();
    rd(5'd12, 32'h0000_0401, "fwd_sr");
    rd(5'd14, 32'h0000_3a04, "fwd_epc");
    check_val("epcdata_reg", EPCData, 32'h0000_3a04);

    // Cause is read-only, unused numbers read 0
    WrEn = 1'b1; WrAddr = 5'd13; WrData = 32'hffff_ffff;
    step();
    idle();
    rd(5'd13, 32'h0000_0000, "cause_ro");
    rd(5'd3, 32'h0000_0000, "unused_reg");

    // Reset in mid-run clears state
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(5'd12, 32'h0, "rerst_sr");
    rd(5'd14, 32'h0, "rerst_epc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
